mips_run_monitor: RTL
=====================

Name: mips_run_monitor

Overview:
- Synthesizable run monitor for the pipelined MIPS core. It sits beside the core and taps the write-back port, the data-memory write port and the PC.
- Sequences a bounded run: start, cycle count, halt detect, timeout, drain.
- Streams every architectural commit (register write, memory write) out through a valid/ready trace FIFO. This replaces ad-hoc waveform dumping of the register file and data memory.
- Parametrised in data width, address widths, trace depth, cycle budget and halt criterion.

Parameters:
- DATA_W, 32: data width of register and memory values.
- REG_ADDR_W, 5: register-file address width.
- MEM_ADDR_W, 10: data-memory word-address width. Must be >= REG_ADDR_W.
- FIFO_DEPTH, 16: number of trace entries. Power of two, >= 2.
- MAX_CYCLES, 500: cycle budget per run.
- HALT_STABLE, 4: number of consecutive cycles with an unchanged PC that declares a halt.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; begins a run from IDLE or DONE.
- pc_i  in  DATA_W  fetch PC of the core.
- rf_we_i  in  1  register-file write enable (write-back stage).
- rf_waddr_i  in  REG_ADDR_W  register write address.
- rf_wdata_i  in  DATA_W  register write data.
- dm_we_i  in  1  data-memory write enable.
- dm_addr_i  in  MEM_ADDR_W  data-memory word address.
- dm_wdata_i  in  DATA_W  data-memory write data.
- trace_valid_o  out  1  trace entry available.
- trace_ready_i  in  1  consumer accepts the entry.
- trace_kind_o  out  1  0 = register write, 1 = memory write.
- trace_addr_o  out  MEM_ADDR_W  address; register addresses are zero-extended.
- trace_data_o  out  DATA_W  written value.
- state_o  out  2  FSM state.
- cycle_count_o  out  $clog2(MAX_CYCLES+1)  RUN cycles elapsed.
- dropped_o  out  16  entries lost to a full FIFO; saturates at 0xFFFF.
- done_o  out  1  run complete.
- timeout_o  out  1  run ended by budget rather than by halt.
- checksum_o  out  DATA_W  see Optional Feature.

Behaviour:
- Clock: single clock clk. Reset: synchronous, active-high.
- Reset values: state IDLE, FIFO empty, trace_valid_o 0, all counters 0, done_o 0, timeout_o 0, checksum_o 0.
- Reset asserted mid-run aborts immediately. Queued trace entries are discarded.
- FSM states: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - IDLE --start_i--> RUN.
  - DONE --start_i--> RUN.
  - On entering RUN: cycle_count, dropped, halt counter, done_o, timeout_o and checksum are cleared. The FIFO is not flushed.
  - start_i is ignored while in RUN or DRAIN.
- RUN, every cycle:
  - cycle_count increments by 1.
  - Halt counter: increments if pc_i equals its previous-cycle value, otherwise resets to 0. The first RUN cycle counts as a change.
  - Halt counter reaching HALT_STABLE -> DRAIN, with timeout_o left at 0.
  - cycle_count reaching MAX_CYCLES -> DRAIN, with timeout_o=1.
  - If both conditions occur in the same cycle, halt wins and timeout_o stays 0.
- Capture (RUN only, including the cycle that exits to DRAIN):
  - An rf_we_i write with rf_waddr_i==0 is ignored.
  - Register event and memory event in the same cycle: the memory entry is pushed first, then the register entry. This takes 2 slots.
  - Free slots count after the same-cycle pop, so a pop frees a slot for that cycle's push.
  - Only 1 free slot: the memory entry is kept, the register entry is dropped, and dropped increments by 1.
  - 0 free slots: every event is dropped, and dropped increments by the number of events.
- Trace output:
  - The FIFO head is registered.
  - An entry is pushed in cycle N and first visible on the outputs in cycle N+1.
  - A pop occurs when trace_valid_o && trace_ready_i.
  - Outputs are held stable while valid && !ready.
- DRAIN: no capture. Moves to DONE in the cycle after the FIFO is observed empty.
- DONE: done_o=1. The final cycle_count is held.

Optional Feature:
- Macro: MIPS_MON_CHECKSUM_EN.
- When defined: checksum_o is updated on each accepted push as checksum = (checksum <<< 1) ^ data ^ zero-extended address, applied in push order. The value is stable in DONE.
- When undefined: checksum_o is tied to 0 and no checksum logic is generated.

Decomposition:
- Package mips_mon_pkg: state encoding constants (IDLE, RUN, DRAIN, DONE) and trace-kind constants (KIND_REG, KIND_MEM).
- Sub-module mon_trace_fifo: dual-push, single-pop FIFO with a registered head. Outputs free-slot count, full and empty.
- mips_run_monitor holds the FSM, counters, capture arbitration and the optional checksum.

Test Plan:
- Reset -> start -> 3 writes (r1=5, r2=7, mem[4]=12), then PC held constant, ready=1 -> 3 entries in order; DONE after halt plus drain; timeout_o=0; cycle_count = 3 + HALT_STABLE + 1.
- PC increments every cycle, MAX_CYCLES=20 -> DRAIN entered when count is 20; done_o=1; timeout_o=1.
- ready=0, FIFO_DEPTH=4, 6 register writes -> 4 entries queued; dropped_o=2; then ready=1 -> entries drained in original order.
- Same-cycle rf write (r3=9) and mem write (mem[8]=3) with 1 slot free -> mem entry queued; dropped_o=1. With 2 or more slots free -> mem entry, then reg entry.
- rf write to r0 -> no entry; dropped_o unchanged.
- Reset asserted mid-RUN with 2 entries queued -> next cycle IDLE, trace_valid_o=0, all counters 0. With MIPS_MON_CHECKSUM_EN: a single push (addr 1, data 0x5) gives checksum_o=0x4.

Source files
------------

// File: rtl/mips_run_monitor_pkg.sv
// mips_mon_pkg: shared encodings for the MIPS run monitor.
// Holds the FSM state codes and the trace-kind tags.
package mips_mon_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;
endpackage

// File: rtl/mips_run_monitor_if.sv
// mips_run_monitor_if: trace stream (valid/ready) from the monitor.
// master: drives valid/kind/addr/data, samples ready; slave: reverse.
interface mips_run_monitor_if #(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10
);
  logic                  valid;
  logic                  ready;
  logic                  kind;
  logic [MEM_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     data;

  modport master (
    output valid, kind, addr, data,
    input  ready
  );

  modport slave (
    input  valid, kind, addr, data,
    output ready
  );
endinterface

// File: rtl/mips_run_monitor_trace_fifo.sv
// mon_trace_fifo: dual-push, single-pop FIFO; head read from flops.
// Ports: push_a/push_b (b only with a), pop, head, free, full, empty.
module mon_trace_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int FW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_a,
  input  logic [W-1:0]  data_a,
  input  logic          push_b,
  input  logic [W-1:0]  data_b,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [FW-1:0] free,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] count;
  logic [1:0]    n_push;
  logic          pop_ok;

  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign pop_ok = pop && !empty;
  assign head   = mem[rd_ptr];
  assign full   = count == FW'(DEPTH);
  assign empty  = count == '0;
  // slots available to this cycle's pushes, counting this cycle's pop
  assign free   = FW'(DEPTH) - count + FW'(pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + FW'(n_push) - FW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= data_a;
    if (push_b) mem[wr_ptr + AW'(1)] <= data_b;
  end
endmodule

// File: rtl/mips_run_monitor.sv
// mips_run_monitor: bounded-run sequencer and commit tracer for the core.
// Taps pc/wb/dmem write ports, streams commits on trace; optional
// checksum of pushed entries when MIPS_MON_CHECKSUM_EN is defined.
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_ADDR_W  = 10,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_CYCLES  = 500,
  parameter int HALT_STABLE = 4,
  localparam int CW = $clog2(MAX_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     pc_i,
  input  logic                  rf_we_i,
  input  logic [REG_ADDR_W-1:0] rf_waddr_i,
  input  logic [DATA_W-1:0]     rf_wdata_i,
  input  logic                  dm_we_i,
  input  logic [MEM_ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  mips_run_monitor_if.master    trace,
  output logic [1:0]            state_o,
  output logic [CW-1:0]         cycle_count_o,
  output logic [15:0]           dropped_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [DATA_W-1:0]     checksum_o
);
  localparam int EW = 1 + MEM_ADDR_W + DATA_W;
  localparam int HW = $clog2(HALT_STABLE + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  state_t            state, nxt;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [HW-1:0]     hc, hc_nx;
  logic [DATA_W-1:0] pc_q;
  logic [15:0]       drop;
  logic [16:0]       drop_sum;
  logic              tmo;
  logic              run, enter, halt, budget;
  logic              rf_ev, dm_ev;
  logic              push_a, push_b, pop;
  logic [EW-1:0]     data_a, data_b, head, mem_e, reg_e;
  logic [FW-1:0]     free;
  logic              full, empty, room2;
  logic [1:0]        n_drop;

  assign run    = state == RUN;
  assign enter  = start_i && (state == IDLE || state == DONE);
  assign cnt_nx = cnt + CW'(1);
  // cnt is zero only in the first RUN cycle, which counts as a PC change
  assign hc_nx  = (cnt != '0 && pc_i == pc_q) ? hc + HW'(1) : '0;
  assign halt   = hc_nx == HW'(HALT_STABLE);
  assign budget = cnt_nx == CW'(MAX_CYCLES);

  assign rf_ev = run && rf_we_i && rf_waddr_i != '0;
  assign dm_ev = run && dm_we_i;
  assign mem_e = {KIND_MEM, dm_addr_i, dm_wdata_i};
  assign reg_e = {KIND_REG, MEM_ADDR_W'(rf_waddr_i), rf_wdata_i};
  assign room2 = free >= FW'(2);
  assign pop   = !empty && trace.ready;

  // memory write takes the first slot; register write the second
  always_comb begin
    push_a = 1'b0;
    push_b = 1'b0;
    data_a = reg_e;
    data_b = reg_e;
    n_drop = 2'd0;
    if (dm_ev) begin
      data_a = mem_e;
      if (!full || pop) begin
        push_a = 1'b1;
        push_b = rf_ev && room2;
        n_drop = {1'b0, rf_ev && !room2};
      end else begin
        n_drop = {1'b0, 1'b1} + {1'b0, rf_ev};
      end
    end else if (rf_ev) begin
      if (!full || pop) push_a = 1'b1;
      else n_drop = 2'd1;
    end
  end

  mon_trace_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_a (push_a),
    .data_a (data_a),
    .push_b (push_b),
    .data_b (data_b),
    .pop    (pop),
    .head   (head),
    .free   (free),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: if (start_i) nxt = RUN;
      RUN:        if (halt || budget) nxt = DRAIN;
      DRAIN:      if (empty) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  assign drop_sum = {1'b0, drop} + {15'd0, n_drop};

  always_ff @(posedge clk) begin
    if (reset || enter) begin
      cnt  <= '0;
      hc   <= '0;
      drop <= '0;
      tmo  <= 1'b0;
      if (reset) pc_q <= '0;
    end else if (run) begin
      cnt  <= cnt_nx;
      hc   <= hc_nx;
      pc_q <= pc_i;
      drop <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      tmo  <= budget && !halt;
    end
  end

`ifdef MIPS_MON_CHECKSUM_EN
  logic [DATA_W-1:0] csum, csum_a, csum_nx;

  function automatic logic [DATA_W-1:0] mix(
    input logic [DATA_W-1:0] c,
    input logic [EW-1:0]     e
  );
    return (c <<< 1) ^ e[DATA_W-1:0]
         ^ DATA_W'(e[DATA_W +: MEM_ADDR_W]);
  endfunction

  assign csum_a  = push_a ? mix(csum, data_a) : csum;
  assign csum_nx = push_b ? mix(csum_a, data_b) : csum_a;

  always_ff @(posedge clk) begin
    if (reset || enter) csum <= '0;
    else if (run)       csum <= csum_nx;
  end

  assign checksum_o = csum;
`else
  assign checksum_o = '0;
`endif

  assign trace.valid = !empty;
  assign {trace.kind, trace.addr, trace.data} = head;

  assign state_o       = state;
  assign cycle_count_o = cnt;
  assign dropped_o     = drop;
  assign done_o        = state == DONE;
  assign timeout_o     = tmo;
endmodule
